// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FP sequencer, its FCSR sub-block and the FP ALU:
// opcode encodings, default execution latencies, FCSR field positions, the
// sequencer state enum and small helpers for latency lookup and cause decode.
// No ports (package).
// -----------------------------------------------------------------------------
package fpu_pkg;

  // Opcode encodings; anything above OP_MAX_LEGAL is unimplemented.
  localparam logic [3:0] OP_ADD       = 4'b0000;
  localparam logic [3:0] OP_SUB       = 4'b0001;
  localparam logic [3:0] OP_MUL       = 4'b0010;
  localparam logic [3:0] OP_CMP       = 4'b0011;
  localparam logic [3:0] OP_DIV       = 4'b0100;
  localparam logic [3:0] OP_SQRT      = 4'b0101;
  localparam logic [3:0] OP_NEG       = 4'b0110;
  localparam logic [3:0] OP_MAX_LEGAL = 4'b0110;

  // Default EXEC latencies in cycles.
  localparam int unsigned DEF_LAT_ADD = 32'd2;
  localparam int unsigned DEF_LAT_MUL = 32'd3;
  localparam int unsigned DEF_LAT_DIV = 32'd6;

  // Cycle counter width and the value that marks the sample cycle.
  localparam int               CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_ONE = 8'd1;

  // FCSR layout: implemented bits [17:0], upper bits read as zero.
  localparam int FCSR_W         = 18;
  localparam int FCSR_CAUSE_LSB = 12;  // E,V,Z,O,U,I at [17:12]
  localparam int FCSR_EN_LSB    = 7;   // V,Z,O,U,I   at [11:7]
  localparam int FCSR_FLAG_LSB  = 2;   // V,Z,O,U,I   at [6:2]
  localparam int FCSR_RM_LSB    = 0;   // RM at [1:0], stored only

  // Bit positions inside the 6-bit cause vector {E,V,Z,O,U,I}.
  localparam int CAUSE_E = 5;
  localparam int CAUSE_V = 4;
  localparam int CAUSE_Z = 3;
  localparam int CAUSE_O = 2;
  localparam int CAUSE_U = 1;
  localparam int CAUSE_I = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10,
    ST_TRAP = 2'b11
  } fpu_state_e;

  // EXEC cycle count for an opcode. Compare and unimplemented opcodes take a
  // single cycle; unimplemented ones only need one cycle to raise E.
  function automatic logic [CNT_W-1:0] op_latency(input logic [3:0]  op,
                                                  input int unsigned lat_add,
                                                  input int unsigned lat_mul,
                                                  input int unsigned lat_div);
    logic [CNT_W-1:0] lat;
    case (op)
      OP_ADD, OP_SUB, OP_NEG: lat = CNT_W'(lat_add);
      OP_MUL:                 lat = CNT_W'(lat_mul);
      OP_DIV, OP_SQRT:        lat = CNT_W'(lat_div);
      OP_CMP:                 lat = CNT_ONE;
      default:                lat = CNT_ONE;
    endcase
    return lat;
  endfunction

  // Build the {E,V,Z,O,U,I} cause vector from the opcode and ALU status.
  function automatic logic [5:0] build_cause(input logic [3:0] op,
                                             input logic qnan,
                                             input logic snan,
                                             input logic dbz,
                                             input logic ovf,
                                             input logic unf,
                                             input logic inexact);
    logic [5:0] c;
    c          = 6'b000000;
    c[CAUSE_E] = (op > OP_MAX_LEGAL);
    c[CAUSE_V] = qnan | snan;
    c[CAUSE_Z] = dbz;
    c[CAUSE_O] = ovf;
    c[CAUSE_U] = unf;
    c[CAUSE_I] = inexact;
    return c;
  endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// fpu_sequencer_if
// Bundles the issue request, ALU drive/status, FCSR access, writeback and trap
// signals of the FP sequencer.
//   slave  : the sequencer side (fpu_sequencer)
//   master : the environment side (core pipeline + combinational FP ALU)
// -----------------------------------------------------------------------------
interface fpu_sequencer_if;
  // issue
  logic        start;
  logic [3:0]  op_in;
  logic [31:0] fa_in;
  logic [31:0] fb_in;
  logic [4:0]  fd_in;
  // ALU drive and status
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_dbz;
  logic        alu_qnan;
  logic        alu_snan;
  logic        alu_inexact;
  logic        alu_underflow;
  logic        alu_overflow;
  // FCSR software access
  logic        fcsr_we;
  logic [31:0] fcsr_wdata;
  logic [31:0] fcsr_rdata;
  // completion
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        fp_cond;
  logic        trap;
  logic        trap_ack;

  modport slave (
    input  start, op_in, fa_in, fb_in, fd_in,
    input  alu_result, alu_zero, alu_dbz, alu_qnan, alu_snan,
    input  alu_inexact, alu_underflow, alu_overflow,
    input  fcsr_we, fcsr_wdata, trap_ack,
    output alu_opcode, alu_a, alu_b, fcsr_rdata,
    output busy, done, wb_en, wb_addr, wb_data, fp_cond, trap
  );

  modport master (
    output start, op_in, fa_in, fb_in, fd_in,
    output alu_result, alu_zero, alu_dbz, alu_qnan, alu_snan,
    output alu_inexact, alu_underflow, alu_overflow,
    output fcsr_we, fcsr_wdata, trap_ack,
    input  alu_opcode, alu_a, alu_b, fcsr_rdata,
    input  busy, done, wb_en, wb_addr, wb_data, fp_cond, trap
  );
endinterface

// File: rtl/fpu_fcsr.sv
// -----------------------------------------------------------------------------
// fpu_fcsr
// FP control/status register with cause overwrite and sticky flag merge.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   sw_we      : software write strobe (wins over hardware update)
//   sw_wdata   : software write data for FCSR[17:0]
//   sample     : the sequencer is sampling ALU status this cycle
//   cause      : {E,V,Z,O,U,I} for the instruction being sampled
//   trap_req   : cause would trap against the current (pre-write) enables
//   rdata      : FCSR read value, bits [31:18] zero
// -----------------------------------------------------------------------------
module fpu_fcsr
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_we,
  input  logic [FCSR_W-1:0] sw_wdata,
  input  logic              sample,
  input  logic [5:0]        cause,
  output logic              trap_req,
  output logic [31:0]       rdata
);

  logic [FCSR_W-1:0] fcsr_q;
  logic [FCSR_W-1:0] fcsr_d;
  logic [4:0]        enables_s;

  assign enables_s = fcsr_q[FCSR_EN_LSB +: 5];
  // V..I occupy the same order in cause, enables and flags.
  assign trap_req  = cause[CAUSE_E] | (|(cause[4:0] & enables_s));
  assign rdata     = {{(32-FCSR_W){1'b0}}, fcsr_q};

  // Next FCSR: software write wins outright, else cause overwrite and merge.
  always_comb begin
    fcsr_d = fcsr_q;
    if (sw_we) begin
      fcsr_d = sw_wdata;
    end else if (sample) begin
      fcsr_d[FCSR_CAUSE_LSB +: 6] = cause;
      if (!trap_req) begin
        fcsr_d[FCSR_FLAG_LSB +: 5] = fcsr_q[FCSR_FLAG_LSB +: 5] | cause[4:0];
      end else begin
        fcsr_d[FCSR_FLAG_LSB +: 5] = fcsr_q[FCSR_FLAG_LSB +: 5];
      end
    end else begin
      fcsr_d = fcsr_q;
    end
  end

  // FCSR storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcsr_q <= {FCSR_W{1'b0}};
    end else begin
      fcsr_q <= fcsr_d;
    end
  end

endmodule

// File: rtl/fpu_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_sequencer
// Issues one FP operation at a time to a combinational FP ALU, waits the
// opcode's latency, samples the ALU status, updates the FCSR and either writes
// the result back or raises a trap that software must acknowledge.
// Parameters: LAT_ADD, LAT_MUL, LAT_DIV - EXEC cycles per opcode class.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fpu_sequencer_if.slave (issue, ALU drive/status, FCSR access,
//              busy/done, writeback, fp_cond, trap/trap_ack)
// -----------------------------------------------------------------------------
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD = DEF_LAT_ADD,
  parameter int unsigned LAT_MUL = DEF_LAT_MUL,
  parameter int unsigned LAT_DIV = DEF_LAT_DIV
) (
  input  logic           clk,
  input  logic           rst,
  fpu_sequencer_if.slave bus
);

  fpu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [4:0]       dest_q, dest_d;
  logic [31:0]      result_q, result_d;
  logic             fp_cond_q, fp_cond_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wb_en_q, wb_en_d;
  logic             trap_q, trap_d;

  logic             sample_s;
  logic             trap_req_s;
  logic [5:0]       cause_s;
  logic             unused_wdata_hi;

  // Only FCSR[17:0] is implemented; the upper write bits are dropped.
  assign unused_wdata_hi = ^bus.fcsr_wdata[31:FCSR_W];

  assign cause_s = build_cause(opcode_q, bus.alu_qnan, bus.alu_snan, bus.alu_dbz,
                               bus.alu_overflow, bus.alu_underflow, bus.alu_inexact);

  fpu_fcsr u_fcsr (
    .clk      (clk),
    .rst      (rst),
    .sw_we    (bus.fcsr_we),
    .sw_wdata (bus.fcsr_wdata[FCSR_W-1:0]),
    .sample   (sample_s),
    .cause    (cause_s),
    .trap_req (trap_req_s),
    .rdata    (bus.fcsr_rdata)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opcode_d  = opcode_q;
    a_d       = a_q;
    b_d       = b_q;
    dest_d    = dest_q;
    result_d  = result_q;
    fp_cond_d = fp_cond_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    trap_d    = 1'b0;
    sample_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          opcode_d = bus.op_in;
          a_d      = bus.fa_in;
          b_d      = bus.fb_in;
          dest_d   = bus.fd_in;
          cnt_d    = op_latency(bus.op_in, LAT_ADD, LAT_MUL, LAT_DIV);
          state_d  = ST_EXEC;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_EXEC: begin
        // <= also covers a zero latency parameter, which acts as one cycle.
        if (cnt_q <= CNT_ONE) begin
          sample_s = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
          result_d = bus.alu_result;
          done_d   = 1'b1;
          if (trap_req_s) begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
          end else begin
            state_d   = ST_WB;
            wb_en_d   = 1'b1;
            fp_cond_d = bus.alu_zero;
          end
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = ST_EXEC;
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      ST_TRAP: begin
        if (bus.trap_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      opcode_q  <= 4'b0000;
      a_q       <= 32'h0000_0000;
      b_q       <= 32'h0000_0000;
      dest_q    <= 5'b00000;
      result_q  <= 32'h0000_0000;
      fp_cond_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opcode_q  <= opcode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dest_q    <= dest_d;
      result_q  <= result_d;
      fp_cond_q <= fp_cond_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      trap_q    <= trap_d;
    end
  end

  assign bus.alu_opcode = opcode_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wb_en      = wb_en_q;
  assign bus.wb_addr    = dest_q;
  assign bus.wb_data    = result_q;
  assign bus.fp_cond    = fp_cond_q;
  assign bus.trap       = trap_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fpu_sequencer
// Drives fpu_sequencer with directed and randomized operations and checks it
// against a transaction-level reference model of the FCSR, fp_cond, timing
// and writeback. The bench plays the role of the FP ALU: it presents random
// status every EXEC cycle and the model uses the values present at the edge
// where the operation's latency expires.
// -----------------------------------------------------------------------------
module tb_fpu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_fcsr;
  logic        m_cond;

  fpu_sequencer_if bus();

  fpu_sequencer #(.LAT_ADD(2), .LAT_MUL(3), .LAT_DIV(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_latency(input logic [3:0] op);
    if (op == 4'd0 || op == 4'd1 || op == 4'd6) return 2;
    if (op == 4'd2) return 3;
    if (op == 4'd4 || op == 4'd5) return 6;
    return 1;
  endfunction

  // flg: [6]=zero [5]=dbz [4]=qnan [3]=snan [2]=inexact [1]=underflow [0]=overflow
  task automatic drive_alu(input logic [31:0] res, input logic [6:0] flg);
    bus.alu_result    = res;
    bus.alu_zero      = flg[6];
    bus.alu_dbz       = flg[5];
    bus.alu_qnan      = flg[4];
    bus.alu_snan      = flg[3];
    bus.alu_inexact   = flg[2];
    bus.alu_underflow = flg[1];
    bus.alu_overflow  = flg[0];
  endtask

  function automatic logic [6:0] rand_flags();
    logic [6:0] f;
    for (int j = 0; j < 7; j++) f[j] = ($urandom_range(0, 5) == 0);
    return f;
  endfunction

  // Software FCSR write in an idle cycle.
  task automatic set_fcsr(input logic [31:0] d);
    bus.fcsr_we    = 1'b1;
    bus.fcsr_wdata = d;
    @(posedge clk); #1;
    bus.fcsr_we = 1'b0;
    m_fcsr = d & 32'h0003_FFFF;
    check("fcsr_sw_write", bus.fcsr_rdata, m_fcsr);
  endtask

  // One complete operation from an IDLE cycle back to an IDLE cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] fd, input bit force_alu,
                        input logic [31:0] f_res, input logic [6:0] f_flg,
                        input bit sw_we, input logic [31:0] sw_data, input bit spam);
    int          lat;
    int          n_busy;
    int          n_done;
    int          n_wb;
    int          w;
    logic [31:0] s_res;
    logic [6:0]  s_flg;
    logic [5:0]  cause;
    bit          e;
    bit          tr;

    lat    = exp_latency(op);
    n_busy = 0;
    n_done = 0;
    n_wb   = 0;
    s_res  = 32'h0;
    s_flg  = 7'h0;
    check("idle_busy", bus.busy, 1'b0);

    bus.start = 1'b1;
    bus.op_in = op;
    bus.fa_in = a;
    bus.fb_in = b;
    bus.fd_in = fd;
    @(posedge clk); #1;
    bus.start = spam;
    bus.op_in = 4'($urandom);
    bus.fa_in = $urandom;
    bus.fb_in = $urandom;
    bus.fd_in = 5'($urandom);
    check("alu_opcode", bus.alu_opcode, op);
    check("alu_a", bus.alu_a, a);
    check("alu_b", bus.alu_b, b);

    for (int k = 1; k <= lat; k++) begin
      s_res = $urandom;
      s_flg = rand_flags();
      if (k == lat && force_alu) begin
        s_res = f_res;
        s_flg = f_flg;
      end
      drive_alu(s_res, s_flg);
      if (k == lat) begin
        bus.fcsr_we    = sw_we;
        bus.fcsr_wdata = sw_data;
      end
      bus.trap_ack = 1'($urandom_range(0, 1));
      n_busy += int'(bus.busy);
      n_done += int'(bus.done);
      n_wb   += int'(bus.wb_en);
      @(posedge clk); #1;
      bus.fcsr_we = 1'b0;
      if (spam) begin
        bus.op_in = 4'($urandom);
        bus.fa_in = $urandom;
      end
    end
    bus.trap_ack = 1'b0;
    drive_alu($urandom, rand_flags());
    check("exec_wb_en", n_wb, 0);

    // reference model for the sampled status
    e     = (op > 4'd6);
    cause = {e, s_flg[4] | s_flg[3], s_flg[5], s_flg[0], s_flg[1], s_flg[2]};
    tr    = e || ((cause[4:0] & m_fcsr[11:7]) != 5'd0);
    m_fcsr[17:12] = cause;
    if (!tr) begin
      m_fcsr[6:2] = m_fcsr[6:2] | cause[4:0];
      m_cond      = s_flg[6];
    end
    if (sw_we) m_fcsr = sw_data & 32'h0003_FFFF;

    n_busy += int'(bus.busy);
    n_done += int'(bus.done);
    check("end_trap", bus.trap, tr);
    check("end_wb_en", bus.wb_en, !tr);
    check("fcsr", bus.fcsr_rdata, m_fcsr);
    check("fp_cond", bus.fp_cond, m_cond);
    check("held_opcode", bus.alu_opcode, op);

    if (tr) begin
      bus.start = 1'b0;
      check("trap_entry_done", bus.done, 1'b1);
      w = $urandom_range(0, 2);
      for (int k = 0; k < w; k++) begin
        @(posedge clk); #1;
        check("trap_hold", {bus.trap, bus.done, bus.wb_en, bus.busy}, 4'b1001);
      end
      bus.trap_ack = 1'b1;
      @(posedge clk); #1;
      bus.trap_ack = 1'b0;
      check("trap_exit", {bus.trap, bus.busy}, 2'b00);
    end else begin
      check("wb_addr", bus.wb_addr, fd);
      check("wb_data", bus.wb_data, s_res);
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_busy += int'(bus.busy);
      n_done += int'(bus.done);
      check("post_wb_wb_en", bus.wb_en, 1'b0);
      check("busy_cycles", n_busy, lat + 1);
      check("done_count", n_done, 1);
    end
  endtask

  // Reset in the middle of a divide: everything clears at once, no writeback.
  task automatic reset_abort();
    int n_wb;
    n_wb = 0;
    set_fcsr(32'h0000_007F);
    bus.start = 1'b1;
    bus.op_in = 4'd4;
    bus.fa_in = 32'h4000_0000;
    bus.fb_in = 32'h3F80_0000;
    bus.fd_in = 5'd9;
    drive_alu(32'h4000_0000, 7'b0000101);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("abort_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("abort_busy0", bus.busy, 1'b0);
    check("abort_opcode0", bus.alu_opcode, 4'd0);
    check("abort_a0", bus.alu_a, 32'h0);
    check("abort_b0", bus.alu_b, 32'h0);
    check("abort_fcsr0", bus.fcsr_rdata, 32'h0);
    check("abort_outs0", {bus.done, bus.wb_en, bus.trap, bus.fp_cond}, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      n_wb += int'(bus.wb_en);
    end
    rst = 1'b0;
    m_fcsr = 32'h0;
    m_cond = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_wb += int'(bus.wb_en);
    end
    check("abort_no_wb", n_wb, 0);
    run_op(4'd0, 32'h3FC0_0000, 32'h4010_0000, 5'd3, 1'b1, 32'h4070_0000, 7'b0000000,
           1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] d;
    bus.start      = 1'b0;
    bus.op_in      = 4'd0;
    bus.fa_in      = 32'h0;
    bus.fb_in      = 32'h0;
    bus.fd_in      = 5'd0;
    bus.fcsr_we    = 1'b0;
    bus.fcsr_wdata = 32'h0;
    bus.trap_ack   = 1'b0;
    drive_alu(32'h0, 7'h00);
    m_fcsr = 32'h0;
    m_cond = 1'b0;

    #2 rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_outs", {bus.done, bus.wb_en, bus.trap, bus.fp_cond}, 4'b0000);
    check("rst_fcsr", bus.fcsr_rdata, 32'h0);
    check("rst_alu_a", bus.alu_a, 32'h0);
    check("rst_wb_data", bus.wb_data, 32'h0);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1.5 + 2.25 with all enables clear
    set_fcsr(32'h0);
    run_op(4'd0, 32'h3FC0_0000, 32'h4010_0000, 5'd3, 1'b1, 32'h4070_0000, 7'b0000000,
           1'b0, 32'h0, 1'b0);
    check("add_flags_zero", bus.fcsr_rdata[6:2], 5'b00000);

    // divide by zero: sticky Z and writeback, then trapping with Z enabled
    set_fcsr(32'h0);
    run_op(4'd4, 32'h3F80_0000, 32'h0, 5'd5, 1'b1, 32'h7F80_0000, 7'b0100000,
           1'b0, 32'h0, 1'b0);
    check("dbz_flag_z", bus.fcsr_rdata, 32'h0000_8020);
    set_fcsr(32'h0000_0400);
    run_op(4'd4, 32'h3F80_0000, 32'h0, 5'd5, 1'b1, 32'h7F80_0000, 7'b0100000,
           1'b0, 32'h0, 1'b0);

    // unimplemented opcode traps with enables clear
    set_fcsr(32'h0000_0001);
    run_op(4'd7, 32'h1, 32'h2, 5'd1, 1'b1, 32'h0, 7'b0000000, 1'b0, 32'h0, 1'b0);
    check("unimpl_cause", bus.fcsr_rdata, 32'h0002_0001);

    // start held every cycle of a multiply
    run_op(4'd2, 32'h4000_0000, 32'h4040_0000, 5'd7, 1'b1, 32'h40C0_0000, 7'b0000000,
           1'b0, 32'h0, 1'b1);

    // compare of equal operands still writes back zero
    run_op(4'd3, 32'h4120_0000, 32'h4120_0000, 5'd8, 1'b1, 32'h0, 7'b1000000,
           1'b0, 32'h0, 1'b0);

    // software write on the sample edge of an overflowing multiply
    set_fcsr(32'h0000_0002);
    run_op(4'd2, 32'h7F00_0000, 32'h7F00_0000, 5'd10, 1'b1, 32'h7F80_0000, 7'b0000101,
           1'b1, 32'h0, 1'b0);
    check("sw_wins_fcsr0", bus.fcsr_rdata, 32'h0);

    reset_abort();

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (n % 5 == 0) begin
        d = $urandom;
        for (int j = 7; j < 12; j++) d[j] = ($urandom_range(0, 3) == 0);
        set_fcsr(d);
      end
      if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(7, 15));
      else                           op = 4'($urandom_range(0, 6));
      run_op(op, $urandom, $urandom, 5'($urandom), 1'b0, 32'h0, 7'h00,
             ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_sequencer.md
FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 The block SHALL have parameter LAT_ADD, default 2, EXEC cycles for opcodes 0000, 0001 and 0110.
REQ-002 The block SHALL have parameter LAT_MUL, default 3, EXEC cycles for opcode 0010.
REQ-003 The block SHALL have parameter LAT_DIV, default 6, EXEC cycles for opcodes 0100 and 0101; opcode 0011 SHALL always take 1 cycle.
REQ-004 clk  in  1  single clock; all state SHALL change on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  issue request; accepted only in IDLE.
REQ-007 op_in  in  4  FP opcode. fa_in, fb_in  in  32 each  operands. fd_in  in  5  destination register.
REQ-008 alu_opcode  out  4, alu_a  out  32, alu_b  out  32  registered drive to the combinational FP ALU.
REQ-009 alu_result  in  32, alu_zero, alu_dbz, alu_qnan, alu_snan, alu_inexact, alu_underflow, alu_overflow  in  1 each  ALU outputs.
REQ-010 fcsr_we  in  1, fcsr_wdata  in  32  software (ctc1) FCSR write. fcsr_rdata  out  32  current FCSR.
REQ-011 busy  out  1, done  out  1 (one-cycle pulse), wb_en  out  1, wb_addr  out  5, wb_data  out  32, fp_cond  out  1.
REQ-012 trap  out  1  level; trap_ack  in  1  clears it.

Function
REQ-013 States SHALL be IDLE, EXEC, WB and TRAP; busy SHALL be 1 in EXEC, WB and TRAP.
REQ-014 IDLE with start=1: latch op_in/fa_in/fb_in/fd_in into alu_opcode/alu_a/alu_b/dest, load the cycle counter with the opcode latency, go to EXEC.
REQ-015 start while not IDLE SHALL be ignored, with no queuing.
REQ-016 EXEC: decrement the counter each cycle; when the counter reaches 1, sample all ALU outputs that same edge and leave EXEC.
REQ-017 Result: issue-to-done SHALL equal the latency plus 1 cycle.
REQ-018 Cause mapping: E=opcode>0110, V=qnan|snan, Z=dbz, O=overflow, U=underflow, I=inexact.
REQ-019 Cause bits are FCSR[17:12] (E,V,Z,O,U,I), enables FCSR[11:7] (V,Z,O,U,I), sticky flags FCSR[6:2], RM FCSR[1:0] (stored only, not interpreted).
REQ-020 On the sample edge, cause SHALL be overwritten with the new value.
REQ-021 If E=1 or (cause[V..I] & enables)!=0, go to TRAP; flags and fp_cond SHALL stay unchanged and there SHALL be no writeback.
REQ-022 Otherwise flags |= cause[V..I], fp_cond = alu_zero, go to WB.
REQ-023 WB (one cycle): wb_en=1, wb_addr=dest, wb_data=sampled result, done=1; then IDLE.
REQ-024 Opcode 0011 with a==b (result zero) SHALL still write back 0.
REQ-025 TRAP: trap=1, done=1 on entry cycle only; hold until trap_ack=1, then IDLE on the next edge. trap_ack outside TRAP SHALL be ignored.
REQ-026 fcsr_we in any state SHALL write FCSR[17:0]; bits [31:18] SHALL read 0.
REQ-027 If fcsr_we coincides with the sample edge, the software write SHALL win for all FCSR bits; the state transition still follows REQ-021/022, evaluated against the pre-write enables.
REQ-028 wb_en and done SHALL be 0 in every cycle not listed above.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, counter=0, FCSR=0, fp_cond=0, and all outputs 0 (alu_* included), aborting any in-flight operation without writeback or flag update.
REQ-030 Operation SHALL resume on the first clk edge after rst deasserts.

Structure
REQ-031 Opcode encodings, the latency table, FCSR bit positions and the state enum SHALL live in shared package fpu_pkg, also used by the ALU.
REQ-032 The FCSR register with its sticky/merge logic SHALL be sub-module fpu_fcsr; the sequencer FSM stays in fpu_sequencer.

Verification
REQ-033 Add 1.5+2.25 (0x3FC00000, 0x40100000, fd=3), enables=0: done at issue+3, wb_addr=3, wb_data=0x40700000, flags=0.
REQ-034 Div by 0.0 with FCSR=0: DBZ -> cause Z=1, flags Z=1, writeback at issue+7. Repeat with enable Z=1: trap=1, no wb_en; trap_ack -> IDLE next edge.
REQ-035 Opcode 0111: cause E=1, trap regardless of enables, flags unchanged.
REQ-036 start pulsed every cycle during a mul: only the first accepted; busy high 4 cycles, exactly one done.
REQ-037 rst asserted mid-EXEC of a div: outputs 0 asynchronously (before next edge), no wb_en ever; after release, add completes normally.
REQ-038 fcsr_we=1 with wdata=0 on the sample edge of an overflowing mul: FCSR reads 0 afterward, wb occurs.
